// File: rtl/pew_pkg.sv
// Shared types and elaboration helpers for the pew burst generator bank.
// Lane state encoding and the parameter range check used at elaboration.
package pew_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_TRIG = 3'd1,
      ST_HIGH = 3'd2,
      ST_LOW  = 3'd3,
      ST_COOL = 3'd4
   } state_t;

   // True when a cycle count is at least 1 and fits the lane counter.
   function automatic bit cyc_ok(input int unsigned v, input int unsigned w);
      return (v >= 1) && (64'(v) < (64'd1 << w));
   endfunction

endpackage

// File: rtl/pew_bank_if.sv
// Bundle of the per-lane fire inputs and the trigger/pew/status outputs of pew_bank.
// The master side drives fire and clr; the slave side is the bank itself.
interface pew_bank_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0]   fire;
   logic                  clr;
   logic [CHANNELS-1:0]   trigger;
   logic [CHANNELS-1:0]   pew;
   logic [CHANNELS-1:0]   busy;
   logic [CHANNELS-1:0]   overrun;
   logic [4*CHANNELS-1:0] status;

   modport master (
      output fire, clr,
      input  trigger, pew, busy, overrun, status
   );

   modport slave (
      input  fire, clr,
      output trigger, pew, busy, overrun, status
   );
endinterface

// File: rtl/pew_lane.sv
// One pew lane: fire synchroniser, burst FSM with down-counter and pulse index,
// plus the sticky overrun flag and the completed-burst counter.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | armed, waiting for a fire edge (AUTO: fire level high)
//   TRIG  | scope trigger high for TRIG_CYC cycles
//   HIGH  | pew high for HIGH_CYC cycles
//   LOW   | pew low for LOW_CYC cycles between pulses
//   COOL  | dead time of COOLDOWN_CYC cycles before re-arm
module pew_lane
   import pew_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int TRIG_CYC     = 10,
   parameter int HIGH_CYC     = 50,
   parameter int LOW_CYC      = 50,
   parameter int PULSES       = 3,
   parameter int COOLDOWN_CYC = 1000,
   parameter int AUTO         = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fire,
   input  logic       clr,
   output logic       trigger,
   output logic       pew,
   output logic       busy,
   output logic       overrun,
   output logic [3:0] status
);

   localparam logic [CNT_W-1:0] TRIG_LD = CNT_W'(TRIG_CYC - 1);
   localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(LOW_CYC - 1);
   localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYC - 1);
   localparam logic [7:0]       LAST_IDX = 8'(PULSES - 1);

   logic             sync1, sync2, hist;
   logic             fire_edge, start;
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       idx;
   logic             trig_d, pew_d, busy_d;
   logic             cnt_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= fire;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign fire_edge = sync2 & ~hist;
   assign start     = (AUTO != 0) ? sync2 : fire_edge;
   assign cnt_zero  = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = ST_TRIG;
         ST_TRIG: if (cnt_zero) state_nx = ST_HIGH;
         ST_HIGH: if (cnt_zero) state_nx = (idx == LAST_IDX) ? ST_COOL : ST_LOW;
         ST_LOW:  if (cnt_zero) state_nx = ST_HIGH;
         ST_COOL: if (cnt_zero) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Counter reloads with N-1 on every state change, so each state lasts N cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         if (state_nx != state) begin
            case (state_nx)
               ST_TRIG: cnt <= TRIG_LD;
               ST_HIGH: cnt <= HIGH_LD;
               ST_LOW:  cnt <= LOW_LD;
               ST_COOL: cnt <= COOL_LD;
               default: cnt <= '0;
            endcase
         end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
         end
         if (state == ST_IDLE && state_nx == ST_TRIG)
            idx <= '0;
         else if (state == ST_LOW && state_nx == ST_HIGH)
            idx <= idx + 8'd1;
      end
   end

   always_comb begin
      trig_d = (state == ST_TRIG);
      pew_d  = (state == ST_HIGH);
      busy_d = (state != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trigger <= 1'b0;
         pew     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         trigger <= trig_d;
         pew     <= pew_d;
         busy    <= busy_d;
      end
   end

   // clr takes priority over a same-cycle overrun or burst completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         status  <= 4'd0;
      end else if (clr) begin
         overrun <= 1'b0;
         status  <= 4'd0;
      end else begin
         if (fire_edge && state != ST_IDLE)
            overrun <= 1'b1;
         if (state == ST_HIGH && state_nx == ST_COOL)
            status <= status + 4'd1;
      end
   end

endmodule

// File: rtl/pew_bank.sv
// Bank of independent pew lanes between the PMOD fire inputs and the chip top.
// Checks the timing parameters at elaboration and packs per-lane outputs onto the bus.
module pew_bank
   import pew_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 16,
   parameter int TRIG_CYC     = 10,
   parameter int HIGH_CYC     = 50,
   parameter int LOW_CYC      = 50,
   parameter int PULSES       = 3,
   parameter int COOLDOWN_CYC = 1000,
   parameter int AUTO         = 0
) (
   input  logic     clk,
   input  logic     rst,
   pew_bank_if.slave bus
);

   if (!cyc_ok(TRIG_CYC, CNT_W) || !cyc_ok(HIGH_CYC, CNT_W) ||
       !cyc_ok(LOW_CYC, CNT_W) || !cyc_ok(COOLDOWN_CYC, CNT_W)) begin : g_bad_cyc
      $error("pew_bank: a *_CYC parameter is 0 or does not fit CNT_W bits");
   end
   if (PULSES < 1 || PULSES > 255) begin : g_bad_pulses
      $error("pew_bank: PULSES must be in 1..255");
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("pew_bank: CHANNELS must be in 1..16");
   end

   logic [CHANNELS-1:0]   trig_v, pew_v, busy_v, ovr_v;
   logic [4*CHANNELS-1:0] stat_v;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      pew_lane #(
         .CNT_W        (CNT_W),
         .TRIG_CYC     (TRIG_CYC),
         .HIGH_CYC     (HIGH_CYC),
         .LOW_CYC      (LOW_CYC),
         .PULSES       (PULSES),
         .COOLDOWN_CYC (COOLDOWN_CYC),
         .AUTO         (AUTO)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .fire    (bus.fire[i]),
         .clr     (bus.clr),
         .trigger (trig_v[i]),
         .pew     (pew_v[i]),
         .busy    (busy_v[i]),
         .overrun (ovr_v[i]),
         .status  (stat_v[4*i +: 4])
      );
   end

   assign bus.trigger = trig_v;
   assign bus.pew     = pew_v;
   assign bus.busy    = busy_v;
   assign bus.overrun = ovr_v;
   assign bus.status  = stat_v;

endmodule
